reg_file_mem: RTL and testbench

REG_FILE_MEM -- requirements
Module: reg_file_mem

---
 rtl/mem_pkg.sv | 13 +
 rtl/clear_sequencer.sv | 63 ++++++
 rtl/reg_file_mem.sv | 75 +++++++
 tb/tb_reg_file_mem.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the register-file memory: sweep controller states
// and default geometry.
package mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/clear_sequencer.sv
// Zero-sweep controller: walks an index over every word, one per cycle,
// raising zero_we and busy for exactly DEPTH cycles after a clear request.
module clear_sequencer
  import mem_pkg::*;
#(
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  output logic              busy,
  output logic              zero_we,
  output logic [ADDR_W-1:0] zero_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    zero_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        // clear is deliberately not looked at here, so a sweep never restarts
        zero_we = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign zero_idx = idx_q;

endmodule

// File: rtl/reg_file_mem.sv
// Small register-file memory with one write port, a registered read port
// (write-through bypass) and a multi-cycle clear sweep.
module reg_file_mem
  import mem_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              store,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              clear,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              seq_busy;
  logic              zero_we;
  logic [ADDR_W-1:0] zero_idx;
  logic              wr_acc;

  clear_sequencer #(.DEPTH(DEPTH)) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .busy     (seq_busy),
    .zero_we  (zero_we),
    .zero_idx (zero_idx)
  );

  // A clear request in IDLE takes priority over a coincident store.
  assign wr_acc = store & ~seq_busy & ~clear;

  always_comb begin
    mem_d = mem_q;
    if (zero_we) begin
      mem_d[zero_idx] = '0;
    end
    if (wr_acc) begin
      mem_d[addr] = data;
    end
    rd_valid_d = rd_en;
    // Reading the next-state array gives both write bypass and zero-on-sweep.
    rd_data_d  = rd_en ? mem_d[rd_addr] : rd_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = seq_busy;

endmodule

// File: tb/tb_reg_file_mem.sv
// Scoreboard bench: a default 8x4 instance and a 16x16 instance.
module tb_reg_file_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;

  logic [7:0]  a_data;
  logic        a_store;
  logic [1:0]  a_addr;
  logic        a_rd_en;
  logic [1:0]  a_rd_addr;
  logic        a_clear;
  logic [7:0]  a_rd_data;
  logic        a_rd_valid;
  logic        a_busy;

  logic [15:0] b_data;
  logic        b_store;
  logic [3:0]  b_addr;
  logic        b_rd_en;
  logic [3:0]  b_rd_addr;
  logic        b_clear;
  logic [15:0] b_rd_data;
  logic        b_rd_valid;
  logic        b_busy;

  reg_file_mem u_dut_a (
    .clk      (clk),
    .reset    (rst_a),
    .data     (a_data),
    .store    (a_store),
    .addr     (a_addr),
    .rd_en    (a_rd_en),
    .rd_addr  (a_rd_addr),
    .clear    (a_clear),
    .rd_data  (a_rd_data),
    .rd_valid (a_rd_valid),
    .busy     (a_busy)
  );

  reg_file_mem #(.DATA_W(16), .DEPTH(16)) u_dut_b (
    .clk      (clk),
    .reset    (rst_b),
    .data     (b_data),
    .store    (b_store),
    .addr     (b_addr),
    .rd_en    (b_rd_en),
    .rd_addr  (b_rd_addr),
    .clear    (b_clear),
    .rd_data  (b_rd_data),
    .rd_valid (b_rd_valid),
    .busy     (b_busy)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_a [$];
  logic [15:0] exp_b [$];

  string       chk_name [$];
  logic [31:0] chk_act  [$];
  logic [31:0] chk_exp  [$];

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_name.push_back(name);
    chk_act.push_back(act);
    chk_exp.push_back(exp);
  endtask

  // Monitor: the only process that counts and judges comparisons.
  always @(negedge clk) begin
    string       n;
    logic [31:0] ac, ex;
    logic [15:0] e;
    while (chk_name.size() > 0) begin
      n  = chk_name.pop_front();
      ac = chk_act.pop_front();
      ex = chk_exp.pop_front();
      total++;
      if (ac !== ex) begin
        bad++;
        $display("FAIL %s: got %h want %h", n, ac, ex);
      end
    end
    if (!rst_a && a_rd_valid) begin
      total++;
      if (exp_a.size() == 0) begin
        bad++;
        $display("FAIL a_unexpected_rd_valid: got rd_data=%h with no read pending", a_rd_data);
      end else begin
        e = 16'(exp_a.pop_front());
        if (a_rd_data !== e[7:0]) begin
          bad++;
          $display("FAIL a_rd_data: got %h want %h", a_rd_data, e[7:0]);
        end
      end
    end
    if (!rst_b && b_rd_valid) begin
      total++;
      if (exp_b.size() == 0) begin
        bad++;
        $display("FAIL b_unexpected_rd_valid: got rd_data=%h with no read pending", b_rd_data);
      end else begin
        e = exp_b.pop_front();
        if (b_rd_data !== e) begin
          bad++;
          $display("FAIL b_rd_data: got %h want %h", b_rd_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [1:0] ad, input logic [7:0] d);
    a_store = 1'b1; a_addr = ad; a_data = d;
    tick();
    a_store = 1'b0;
  endtask

  task automatic a_read(input logic [1:0] ad, input logic [7:0] e);
    a_rd_en = 1'b1; a_rd_addr = ad;
    exp_a.push_back(e);
    tick();
    a_rd_en = 1'b0;
  endtask

  task automatic a_wait_idle(output int n);
    n = 0;
    while (a_busy && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic b_write(input logic [3:0] ad, input logic [15:0] d);
    b_store = 1'b1; b_addr = ad; b_data = d;
    tick();
    b_store = 1'b0;
  endtask

  task automatic b_read(input logic [3:0] ad, input logic [15:0] e);
    b_rd_en = 1'b1; b_rd_addr = ad;
    exp_b.push_back(e);
    tick();
    b_rd_en = 1'b0;
  endtask

  task automatic b_wait_idle(output int n);
    n = 0;
    while (b_busy && n < 64) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int busy_n;
    rst_a = 1'b0; rst_b = 1'b0;
    a_data = '0; a_store = 1'b0; a_addr = '0; a_rd_en = 1'b0; a_rd_addr = '0; a_clear = 1'b0;
    b_data = '0; b_store = 1'b0; b_addr = '0; b_rd_en = 1'b0; b_rd_addr = '0; b_clear = 1'b0;
    #1;
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    // Reset values before any clock edge
    expect_eq("a_reset_rd_data", 32'(a_rd_data), 32'h0);
    expect_eq("a_reset_rd_valid", 32'(a_rd_valid), 32'h0);
    expect_eq("a_reset_busy", 32'(a_busy), 32'h0);
    expect_eq("b_reset_busy", 32'(b_busy), 32'h0);
    tick();
    tick();
    rst_a = 1'b0; rst_b = 1'b0;

    // First edge after reset takes the write; single-cycle read pulse, then hold
    a_write(2'd2, 8'hA5);
    a_read(2'd2, 8'hA5);
    tick();
    expect_eq("a_rd_valid_one_cycle", 32'(a_rd_valid), 32'h0);
    expect_eq("a_rd_data_hold", 32'(a_rd_data), 32'hA5);

    // Same-edge write and read of one address: bypass
    a_store = 1'b1; a_addr = 2'd1; a_data = 8'h3C;
    a_rd_en = 1'b1; a_rd_addr = 2'd1;
    exp_a.push_back(8'h3C);
    tick();
    a_store = 1'b0; a_rd_en = 1'b0;

    // Fill, then sweep with a dropped store and reads during the sweep
    a_write(2'd0, 8'h11);
    a_write(2'd1, 8'h22);
    a_write(2'd2, 8'h33);
    a_write(2'd3, 8'h44);
    a_read(2'd2, 8'h33);
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    expect_eq("a_busy_after_clear", 32'(a_busy), 32'h1);
    busy_n = 0;
    if (a_busy) busy_n++;
    a_store = 1'b1; a_addr = 2'd0; a_data = 8'hFF;
    a_rd_en = 1'b1; a_rd_addr = 2'd0;
    exp_a.push_back(8'h00);
    tick();
    a_store = 1'b0; a_rd_en = 1'b0;
    if (a_busy) busy_n++;
    a_rd_en = 1'b1; a_rd_addr = 2'd3; a_clear = 1'b1;
    exp_a.push_back(8'h44);
    tick();
    a_rd_en = 1'b0; a_clear = 1'b0;
    a_wait_idle(n);
    expect_eq("a_busy_cycles", 32'(busy_n + n), 32'd4);
    for (int i = 0; i < 4; i++) a_read(2'(i), 8'h00);

    // Store and clear on one edge: clear wins
    a_write(2'd3, 8'h66);
    a_store = 1'b1; a_addr = 2'd3; a_data = 8'h77; a_clear = 1'b1;
    tick();
    a_store = 1'b0; a_clear = 1'b0;
    a_read(2'd3, 8'h66);
    a_wait_idle(n);
    expect_eq("a_busy_cycles_2", 32'(n + 1), 32'd4);
    a_read(2'd3, 8'h00);

    // Reset mid-sweep with a read outstanding
    a_write(2'd0, 8'h12);
    a_write(2'd2, 8'h34);
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    tick();
    tick();
    a_rd_en = 1'b1; a_rd_addr = 2'd2;
    tick();
    a_rd_en = 1'b0;
    expect_eq("a_rd_valid_before_reset", 32'(a_rd_valid), 32'h1);
    #1;
    rst_a = 1'b1;
    #1;
    expect_eq("a_mid_reset_rd_valid", 32'(a_rd_valid), 32'h0);
    expect_eq("a_mid_reset_busy", 32'(a_busy), 32'h0);
    expect_eq("a_mid_reset_rd_data", 32'(a_rd_data), 32'h0);
    tick();
    tick();
    rst_a = 1'b0;
    expect_eq("a_busy_after_release", 32'(a_busy), 32'h0);
    for (int i = 0; i < 4; i++) a_read(2'(i), 8'h00);

    // Wide/deep instance: address-as-data fill, read back, full sweep
    for (int i = 0; i < 16; i++) b_write(4'(i), 16'(i));
    for (int i = 0; i < 16; i++) b_read(4'(i), 16'(i));
    b_clear = 1'b1;
    tick();
    b_clear = 1'b0;
    expect_eq("b_busy_after_clear", 32'(b_busy), 32'h1);
    b_wait_idle(n);
    expect_eq("b_busy_cycles", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) b_read(4'(i), 16'h0000);

    tick();
    tick();
    expect_eq("a_reads_all_returned", 32'(exp_a.size()), 32'd0);
    expect_eq("b_reads_all_returned", 32'(exp_b.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
